vend_ctrl_multi: RTL and testbench
==================================

// Module: vend_ctrl_multi
// PURPOSE
//  Parametrised multi-product vending controller; successor to the single-price coin FSM.
//  Accepts coded coins into a saturating balance and vends one of NUM_ITEMS products at run-time prices.
//  Returns change or a cancelled balance over a valid/ready handshake.
//  Sits between the coin/keypad input decode and the dispenser/coin-hopper drivers.
// PARAMETERS
//  NUM_ITEMS  4    number of products; sel index width SEL_W=$clog2(NUM_ITEMS) (min 1)
//  BAL_W      8    balance/price/change width, unsigned
//  MAX_BAL    255  highest legal balance; must be <= 2**BAL_W-1
//  COIN1_VAL  5    credit for coin code 2'b01
//  COIN2_VAL  10   credit for coin code 2'b10
//  COIN3_VAL  20   credit for coin code 2'b11 (code 2'b00 = no coin)
// PORTS
//  clk         in   1                  rising-edge clock
//  rst         in   1                  async active-high reset
//  coin        in   2                  coin code, sampled when coin_valid=1
//  coin_valid  in   1                  one-cycle coin strobe
//  sel         in   SEL_W              product index, sampled when sel_valid=1
//  sel_valid   in   1                  one-cycle selection strobe
//  cancel      in   1                  one-cycle refund request
//  prices      in   NUM_ITEMS*BAL_W    price of item i in prices[i*BAL_W +: BAL_W]
//  dispense    out  1                  one-cycle vend pulse
//  item        out  SEL_W              index vended; valid while dispense=1, else holds last value
//  change_valid out 1                  change_amt is valid; held until accepted
//  change_ready in  1                  hopper accepts change
//  change_amt  out  BAL_W              amount to return
//  coin_reject out  1                  one-cycle pulse: coin not credited
//  sel_err     out  1                  one-cycle pulse: sel >= NUM_ITEMS
//  low_funds   out  1                  one-cycle pulse: balance < price
//  balance     out  BAL_W              current credit
//  busy        out  1                  1 in VEND or CHANGE
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0. Async assert; all regs cleared mid-transaction, pending change discarded.
//  States: IDLE (balance=0), CREDIT (balance>0), VEND, CHANGE.
//  Per-cycle input priority in IDLE/CREDIT: cancel > coin_valid > sel_valid.
//   Lower-priority strobes in the same cycle are dropped. A dropped coin pulses coin_reject.
//  Coin: code 00 is rejected. If balance+val > MAX_BAL, reject; balance unchanged (no wrap).
//   Otherwise balance += val next cycle; IDLE->CREDIT.
//   Coins arriving in VEND/CHANGE are rejected.
//  Select: sel >= NUM_ITEMS -> sel_err.
//   balance < price -> low_funds; state unchanged.
//   Else -> VEND with balance -= price. Price 0 vends from IDLE.
//  VEND (1 cycle): dispense=1, item=sel. Next state CHANGE if balance>0, else IDLE.
//  Cancel: CREDIT->CHANGE; IDLE ignores cancel (no pulse).
//  CHANGE: change_valid=1, change_amt=balance, stable until change_ready.
//   On the accepting cycle: balance<=0, ->IDLE. change_ready outside CHANGE is ignored.
//  Latency: strobe->dispense = 1 cycle. Strobe->change_valid = 2 (vend) or 1 (cancel).
//  prices is sampled only on the sel_valid cycle; changing it otherwise has no effect.
// CONFIGURATION
//  VEND_STATS_EN defined: adds ports stat_sel (in, SEL_W) and stat_cnt (out, 16).
//   Keeps a per-item 16-bit sale counter, +1 on each dispense, saturating at 16'hFFFF.
//   stat_cnt = counter[stat_sel] (combinational); stat_sel >= NUM_ITEMS reads 0.
//   Counters are cleared by rst only.
//  VEND_STATS_EN undefined: these ports and counters do not exist; all other behaviour identical.
// TESTING
//  1. Coins 10 then 10, sel=2 (price 15) -> dispense, item=2; change_valid, change_amt=5.
//     change_ready=1 -> balance 0, IDLE.
//  2. Balance 250, coin 20 (MAX_BAL=255) -> coin_reject=1, balance stays 250.
//  3. Balance 5, sel=1 (price 15) -> low_funds=1, no dispense, balance 5.
//     sel=NUM_ITEMS -> sel_err=1.
//  4. Coin and sel same cycle, then cancel and coin same cycle ->
//     coin credited with sel dropped; then refund with coin_reject=1.
//  5. change_ready held 0 for 10 cycles in CHANGE -> change_valid/amt stable, coins rejected.
//     rst asserted mid-CHANGE -> all outputs 0.
//  6. With VEND_STATS_EN: 3 vends of item 0 -> stat_sel=0 reads 3; item 1 reads 0.

Source files
------------

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller.
// Coins build a saturating balance; a selection vends one of NUM_ITEMS products at
// run-time prices; change or a cancelled balance is returned over a valid/ready handshake.
// Optional feature: define VEND_STATS_EN to add per-item sale counters (stat_sel/stat_cnt).
module vend_ctrl_multi #(
  parameter int unsigned NUM_ITEMS = 4,
  parameter int unsigned BAL_W     = 8,
  parameter int unsigned MAX_BAL   = 255,
  parameter int unsigned COIN1_VAL = 5,
  parameter int unsigned COIN2_VAL = 10,
  parameter int unsigned COIN3_VAL = 20,
  localparam int unsigned SEL_W    = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 coin,
  input  logic                       coin_valid,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       sel_valid,
  input  logic                       cancel,
  input  logic [NUM_ITEMS*BAL_W-1:0] prices,
  output logic                       dispense,
  output logic [SEL_W-1:0]           item,
  output logic                       change_valid,
  input  logic                       change_ready,
  output logic [BAL_W-1:0]           change_amt,
  output logic                       coin_reject,
  output logic                       sel_err,
  output logic                       low_funds,
  output logic [BAL_W-1:0]           balance,
  output logic                       busy
`ifdef VEND_STATS_EN
  ,
  input  logic [SEL_W-1:0]           stat_sel,
  output logic [15:0]                stat_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StCredit, StVend, StChange} state_e;

  state_e state_q;

  logic [BAL_W-1:0] coin_val;
  logic [BAL_W:0]   coin_sum;
  logic             coin_ok;
  logic [BAL_W-1:0] sel_price;
  logic             sel_in_range;
  logic             accepting;
  logic             cancel_go;
  logic             vend_go;

  // Credit value of the presented coin code; code 00 carries no credit
  always_comb begin
    coin_val = '0;
    unique case (coin)
      2'b01:   coin_val = BAL_W'(COIN1_VAL);
      2'b10:   coin_val = BAL_W'(COIN2_VAL);
      2'b11:   coin_val = BAL_W'(COIN3_VAL);
      default: coin_val = '0;
    endcase
  end

  // One extra bit so an overflowing sum is caught instead of wrapping
  assign coin_sum = {1'b0, balance} + {1'b0, coin_val};
  assign coin_ok  = (coin_val != '0) && (coin_sum <= (BAL_W+1)'(MAX_BAL));

  // Price lookup for the requested item; only meaningful when sel is in range
  always_comb begin
    sel_price = '0;
    for (int i = 0; i < int'(NUM_ITEMS); i++) begin
      if (sel == SEL_W'(i)) sel_price = prices[i*BAL_W +: BAL_W];
    end
  end

  assign sel_in_range = 32'(sel) < NUM_ITEMS;

  // Strobe arbitration in IDLE/CREDIT: cancel (only with credit) > coin > select
  assign accepting = (state_q == StIdle) || (state_q == StCredit);
  assign cancel_go = (state_q == StCredit) && cancel;
  assign vend_go   = accepting && !cancel_go && !coin_valid && sel_valid && sel_in_range &&
                     (balance >= sel_price);

  assign busy = (state_q == StVend) || (state_q == StChange);

  // Controller FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      dispense     <= 1'b0;
      item         <= '0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      coin_reject  <= 1'b0;
      sel_err      <= 1'b0;
      low_funds    <= 1'b0;
      balance      <= '0;
    end else begin
      dispense    <= 1'b0;
      coin_reject <= 1'b0;
      sel_err     <= 1'b0;
      low_funds   <= 1'b0;
      unique case (state_q)
        StIdle, StCredit: begin
          if (cancel_go) begin
            state_q      <= StChange;
            change_valid <= 1'b1;
            change_amt   <= balance;
            coin_reject  <= coin_valid;
          end else if (coin_valid) begin
            if (coin_ok) begin
              balance <= coin_sum[BAL_W-1:0];
              state_q <= StCredit;
            end else begin
              coin_reject <= 1'b1;
            end
          end else if (sel_valid) begin
            if (!sel_in_range) begin
              sel_err <= 1'b1;
            end else if (!vend_go) begin
              low_funds <= 1'b1;
            end else begin
              balance  <= balance - sel_price;
              state_q  <= StVend;
              dispense <= 1'b1;
              item     <= sel;
            end
          end
        end
        StVend: begin
          coin_reject <= coin_valid;
          if (balance != '0) begin
            state_q      <= StChange;
            change_valid <= 1'b1;
            change_amt   <= balance;
          end else begin
            state_q <= StIdle;
          end
        end
        StChange: begin
          coin_reject <= coin_valid;
          if (change_ready) begin
            state_q      <= StIdle;
            change_valid <= 1'b0;
            change_amt   <= '0;
            balance      <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef VEND_STATS_EN
  logic [15:0] cnt_q [NUM_ITEMS];

  // Per-item sale counters, bumped with the vend decision and saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_ITEMS); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_ITEMS); i++) begin
        if (vend_go && (sel == SEL_W'(i)) && (cnt_q[i] != 16'hFFFF)) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  // Counter readback; out-of-range indices read as zero
  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < int'(NUM_ITEMS); i++) begin
      if (stat_sel == SEL_W'(i)) stat_cnt = cnt_q[i];
    end
  end
`else
  // Statistics disabled: no counters or readback ports
`endif

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Self-checking bench for vend_ctrl_multi: directed scenarios plus randomized traffic
// compared against a transaction-level model of balance and phase.
module tb_vend_ctrl_multi;
  localparam int NI = 3;
  localparam int BW = 8;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    coin;
  logic          coin_valid;
  logic [SW-1:0] sel;
  logic          sel_valid;
  logic          cancel;
  logic [NI*BW-1:0] prices;
  logic          dispense;
  logic [SW-1:0] item;
  logic          change_valid;
  logic          change_ready;
  logic [BW-1:0] change_amt;
  logic          coin_reject;
  logic          sel_err;
  logic          low_funds;
  logic [BW-1:0] balance;
  logic          busy;
`ifdef VEND_STATS_EN
  logic [SW-1:0] stat_sel;
  logic [15:0]   stat_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Model: phase 0 = taking coins/selections, 1 = vending, 2 = returning change
  int m_bal, m_ph, m_item, m_amt;
  bit m_disp, m_cv, m_rej, m_serr, m_low;
  int m_cnt [NI];

  always #5 clk = ~clk;

  vend_ctrl_multi #(.NUM_ITEMS(NI), .BAL_W(BW), .MAX_BAL(255),
                    .COIN1_VAL(5), .COIN2_VAL(10), .COIN3_VAL(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .coin         (coin),
    .coin_valid   (coin_valid),
    .sel          (sel),
    .sel_valid    (sel_valid),
    .cancel       (cancel),
    .prices       (prices),
    .dispense     (dispense),
    .item         (item),
    .change_valid (change_valid),
    .change_ready (change_ready),
    .change_amt   (change_amt),
    .coin_reject  (coin_reject),
    .sel_err      (sel_err),
    .low_funds    (low_funds),
    .balance      (balance),
    .busy         (busy)
`ifdef VEND_STATS_EN
    ,
    .stat_sel     (stat_sel),
    .stat_cnt     (stat_cnt)
`endif
  );

  function automatic int price_of(input int i);
    return int'(prices[i*BW +: BW]);
  endfunction

  function automatic int credit_of(input logic [1:0] c);
    case (c)
      2'b01:   return 5;
      2'b10:   return 10;
      2'b11:   return 20;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_bal = 0; m_ph = 0; m_item = 0; m_amt = 0;
    m_disp = 0; m_cv = 0; m_rej = 0; m_serr = 0; m_low = 0;
    for (int i = 0; i < NI; i++) m_cnt[i] = 0;
  endtask

  // Apply one clock's worth of inputs to the model
  task automatic model_step(input logic [1:0] c, input bit cv, input int s, input bit sv,
                            input bit can, input bit cr);
    m_disp = 0; m_rej = 0; m_serr = 0; m_low = 0;
    if (m_ph == 1) begin
      m_rej = cv;
      if (m_bal > 0) begin m_ph = 2; m_cv = 1; m_amt = m_bal; end
      else m_ph = 0;
    end else if (m_ph == 2) begin
      m_rej = cv;
      if (cr) begin m_bal = 0; m_cv = 0; m_amt = 0; m_ph = 0; end
    end else if (can && m_bal > 0) begin
      m_ph = 2; m_cv = 1; m_amt = m_bal; m_rej = cv;
    end else if (cv) begin
      if (credit_of(c) == 0 || m_bal + credit_of(c) > 255) m_rej = 1;
      else m_bal = m_bal + credit_of(c);
    end else if (sv) begin
      if (s >= NI) m_serr = 1;
      else if (m_bal < price_of(s)) m_low = 1;
      else begin
        m_bal = m_bal - price_of(s); m_ph = 1; m_disp = 1; m_item = s;
        if (m_cnt[s] < 65535) m_cnt[s]++;
      end
    end
  endtask

  // Drive one cycle of strobes, advance the model, sample 1 time unit after the edge
  task automatic step(input logic [1:0] c, input bit cv, input int s, input bit sv,
                      input bit can, input bit cr);
    coin = c; coin_valid = cv; sel = SW'(s); sel_valid = sv; cancel = can; change_ready = cr;
    @(posedge clk);
    model_step(c, cv, s, sv, can, cr);
    #1;
    coin_valid = 0; sel_valid = 0; cancel = 0; change_ready = 0;
  endtask

  task automatic idle_step();
    step(2'b00, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    coin = 0; coin_valid = 0; sel = 0; sel_valid = 0; cancel = 0; change_ready = 0;
    prices = {8'd15, 8'd15, 8'd25};
`ifdef VEND_STATS_EN
    stat_sel = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({dispense, item, change_valid, change_amt, coin_reject, sel_err, low_funds, balance, busy}
        !== 24'd0) begin
      failures++;
      $display("FAIL reset_outputs: got disp=%0b item=%0d cv=%0b amt=%0d rej=%0b serr=%0b low=%0b bal=%0d busy=%0b, want all 0",
               dispense, item, change_valid, change_amt, coin_reject, sel_err, low_funds, balance, busy);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_vend_change();
    do_reset();
    step(2'b10, 1, 0, 0, 0, 0);
    step(2'b10, 1, 0, 0, 0, 0);
    checks++;
    if (balance !== 8'd20) begin
      failures++; $display("FAIL vend_balance20: got %0d want 20", balance);
    end
    step(2'b00, 0, 2, 1, 0, 0);
    checks++;
    if (dispense !== 1'b1 || item !== 2'd2 || balance !== 8'd5 || busy !== 1'b1) begin
      failures++;
      $display("FAIL vend_dispense: got disp=%0b item=%0d bal=%0d busy=%0b want 1 2 5 1",
               dispense, item, balance, busy);
    end
    idle_step();
    checks++;
    if (dispense !== 1'b0 || change_valid !== 1'b1 || change_amt !== 8'd5) begin
      failures++;
      $display("FAIL vend_change: got disp=%0b cv=%0b amt=%0d want 0 1 5", dispense, change_valid, change_amt);
    end
    step(2'b00, 0, 0, 0, 0, 1);
    checks++;
    if (change_valid !== 1'b0 || balance !== 8'd0 || busy !== 1'b0 || item !== 2'd2) begin
      failures++;
      $display("FAIL vend_accept: got cv=%0b bal=%0d busy=%0b item=%0d want 0 0 0 2",
               change_valid, balance, busy, item);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    repeat (12) step(2'b11, 1, 0, 0, 0, 0);
    step(2'b10, 1, 0, 0, 0, 0);
    step(2'b11, 1, 0, 0, 0, 0);
    checks++;
    if (coin_reject !== 1'b1 || balance !== 8'd250) begin
      failures++; $display("FAIL overflow_reject: got rej=%0b bal=%0d want 1 250", coin_reject, balance);
    end
    step(2'b01, 1, 0, 0, 0, 0);
    checks++;
    if (coin_reject !== 1'b0 || balance !== 8'd255) begin
      failures++; $display("FAIL overflow_exact_max: got rej=%0b bal=%0d want 0 255", coin_reject, balance);
    end
    step(2'b00, 1, 0, 0, 0, 0);
    checks++;
    if (coin_reject !== 1'b1 || balance !== 8'd255) begin
      failures++; $display("FAIL coin_code0: got rej=%0b bal=%0d want 1 255", coin_reject, balance);
    end
    step(2'b00, 0, 0, 0, 1, 0);
    checks++;
    if (change_valid !== 1'b1 || change_amt !== 8'd255 || busy !== 1'b1) begin
      failures++;
      $display("FAIL cancel_refund: got cv=%0b amt=%0d busy=%0b want 1 255 1", change_valid, change_amt, busy);
    end
    step(2'b00, 0, 0, 0, 0, 1);
  endtask

  task automatic test_low_funds_sel_err();
    do_reset();
    step(2'b01, 1, 0, 0, 0, 0);
    step(2'b00, 0, 1, 1, 0, 0);
    checks++;
    if (low_funds !== 1'b1 || dispense !== 1'b0 || balance !== 8'd5 || busy !== 1'b0) begin
      failures++;
      $display("FAIL low_funds: got low=%0b disp=%0b bal=%0d busy=%0b want 1 0 5 0",
               low_funds, dispense, balance, busy);
    end
    step(2'b00, 0, NI, 1, 0, 0);
    checks++;
    if (sel_err !== 1'b1 || low_funds !== 1'b0 || dispense !== 1'b0) begin
      failures++; $display("FAIL sel_err: got serr=%0b low=%0b disp=%0b want 1 0 0", sel_err, low_funds, dispense);
    end
    step(2'b00, 0, 0, 0, 1, 0);
    step(2'b00, 0, 0, 0, 0, 1);
    // Zero price vends straight from an empty balance and needs no change
    prices[7:0] = 8'd0;
    step(2'b00, 0, 0, 1, 0, 0);
    checks++;
    if (dispense !== 1'b1 || item !== 2'd0) begin
      failures++; $display("FAIL free_vend: got disp=%0b item=%0d want 1 0", dispense, item);
    end
    idle_step();
    checks++;
    if (busy !== 1'b0 || change_valid !== 1'b0 || dispense !== 1'b0) begin
      failures++;
      $display("FAIL free_vend_idle: got busy=%0b cv=%0b disp=%0b want 0 0 0", busy, change_valid, dispense);
    end
    prices[7:0] = 8'd25;
  endtask

  task automatic test_priority();
    do_reset();
    step(2'b10, 1, 2, 1, 0, 0);
    checks++;
    if (balance !== 8'd10 || dispense !== 1'b0 || sel_err !== 1'b0 || low_funds !== 1'b0) begin
      failures++;
      $display("FAIL coin_over_sel: got bal=%0d disp=%0b serr=%0b low=%0b want 10 0 0 0",
               balance, dispense, sel_err, low_funds);
    end
    step(2'b01, 1, 0, 0, 1, 0);
    checks++;
    if (change_valid !== 1'b1 || change_amt !== 8'd10 || coin_reject !== 1'b1) begin
      failures++;
      $display("FAIL cancel_over_coin: got cv=%0b amt=%0d rej=%0b want 1 10 1", change_valid, change_amt, coin_reject);
    end
    step(2'b00, 0, 0, 0, 0, 1);
  endtask

  task automatic test_change_hold_reset();
    do_reset();
    step(2'b11, 1, 0, 0, 0, 0);
    step(2'b11, 1, 0, 0, 0, 0);
    step(2'b00, 0, 0, 1, 0, 0);
    idle_step();
    for (int i = 0; i < 10; i++) begin
      step(2'($urandom_range(3)), 1, 0, 0, 0, 0);
      checks++;
      if (change_valid !== 1'b1 || change_amt !== 8'd15 || coin_reject !== 1'b1 || busy !== 1'b1) begin
        failures++;
        $display("FAIL change_hold[%0d]: got cv=%0b amt=%0d rej=%0b busy=%0b want 1 15 1 1",
                 i, change_valid, change_amt, coin_reject, busy);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({dispense, item, change_valid, change_amt, coin_reject, sel_err, low_funds, balance, busy}
        !== 24'd0) begin
      failures++;
      $display("FAIL async_reset: got cv=%0b amt=%0d bal=%0d busy=%0b want all 0",
               change_valid, change_amt, balance, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

`ifdef VEND_STATS_EN
  task automatic test_stats();
    do_reset();
    prices[7:0] = 8'd5;
    repeat (3) begin
      step(2'b01, 1, 0, 0, 0, 0);
      step(2'b00, 0, 0, 1, 0, 0);
      idle_step();
    end
    stat_sel = 0; #1;
    checks++;
    if (stat_cnt !== 16'd3) begin
      failures++; $display("FAIL stats_item0: got %0d want 3", stat_cnt);
    end
    stat_sel = 1; #1;
    checks++;
    if (stat_cnt !== 16'd0) begin
      failures++; $display("FAIL stats_item1: got %0d want 0", stat_cnt);
    end
    stat_sel = 3; #1;
    checks++;
    if (stat_cnt !== 16'd0) begin
      failures++; $display("FAIL stats_out_of_range: got %0d want 0", stat_cnt);
    end
    prices[7:0] = 8'd25;
  endtask
`endif

  task automatic test_random();
    logic [23:0] got, exp;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n % 40 == 0) begin
        for (int i = 0; i < NI; i++) prices[i*BW +: BW] = 8'($urandom_range(40));
      end
`ifdef VEND_STATS_EN
      stat_sel = SW'($urandom_range(3));
`endif
      step(2'($urandom_range(3)), ($urandom_range(99) < 40), int'($urandom_range(3)),
           ($urandom_range(99) < 35), ($urandom_range(99) < 8), ($urandom_range(99) < 40));
      got = {dispense, item, change_valid, change_amt, coin_reject, sel_err, low_funds, balance, busy};
      exp = {m_disp, 2'(m_item), m_cv, 8'(m_amt), m_rej, m_serr, m_low, 8'(m_bal), (m_ph != 0)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random_outputs[%0d]: got %h want %h (disp,item,cv,amt,rej,serr,low,bal,busy)",
                 n, got, exp);
      end
`ifdef VEND_STATS_EN
      checks++;
      if (stat_cnt !== ((int'(stat_sel) < NI) ? 16'(m_cnt[stat_sel]) : 16'd0)) begin
        failures++; $display("FAIL random_stats[%0d]: got %0d for item %0d", n, stat_cnt, stat_sel);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_vend_change();
    test_overflow();
    test_low_funds_sel_err();
    test_priority();
    test_change_hold_reset();
`ifdef VEND_STATS_EN
    test_stats();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
